// File: rtl/mp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mp_regfile
// Description : Multi-port integer register file: NRD combinational reads,
//               NWR synchronous writes, x0 hardwired to zero, optional
//               same-cycle write->read bypass, and a clear sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_regfile #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NRD*$clog2(NREG)-1:0]   raddr,
    output logic [NRD*XLEN-1:0]           rdata,
    input  logic [NWR*$clog2(NREG)-1:0]   waddr,
    input  logic [NWR*XLEN-1:0]           wdata,
    input  logic [NWR-1:0]                wen,
    output logic                          init_busy
);

    localparam int AW = $clog2(NREG);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_busy;
    logic [XLEN-1:0] r_rf [NREG];

    // The sweep starts at x1: x0 storage is never written and always reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_INIT;
            r_cnt   <= AW'(1);
            r_busy  <= 1'b1;
        end else if (r_state == S_INIT) begin
            r_rf[r_cnt] <= '0;
            if (r_cnt == AW'(NREG - 1)) begin
                r_cnt   <= '0;
                r_state <= S_RUN;
                r_busy  <= 1'b0;
            end else begin
                r_cnt <= r_cnt + AW'(1);
            end
        end else begin
            // Ascending loop: the last non-blocking write wins, giving the
            // highest-index port priority on address collisions.
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
                    r_rf[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    assign init_busy = r_busy;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_val;

            assign w_addr = raddr[k*AW +: AW];

            always_comb begin
                w_val = '0;
                if ((r_state == S_RUN) && (w_addr != '0)) begin
                    w_val = r_rf[w_addr];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NWR; j++) begin
                            if (wen[j] && (waddr[j*AW +: AW] == w_addr)) begin
                                w_val = wdata[j*XLEN +: XLEN];
                            end
                        end
                    end
                end
            end

            assign rdata[k*XLEN +: XLEN] = w_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_regfile
// Description : Scoreboard bench for mp_regfile; one bypassing and one
//               non-bypassing instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 4;
    localparam int NWR  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset;
    logic [NRD*AW-1:0]    raddr;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NWR-1:0]       wen;
    logic [NRD*XLEN-1:0]  rdata_b;
    logic [NRD*XLEN-1:0]  rdata_n;
    logic                 busy_b;
    logic                 busy_n;

    mp_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_b),
        .waddr(waddr), .wdata(wdata), .wen(wen), .init_busy(busy_b)
    );

    mp_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata_n),
        .waddr(waddr), .wdata(wdata), .wen(wen), .init_busy(busy_n)
    );

    // sel: 0 = rdata bypass dut, 1 = rdata no-bypass dut, 2/3 = init_busy of each
    typedef struct {
        int              sel;
        int              port;
        logic [XLEN-1:0] exp;
        string           name;
    } chk_t;

    chk_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_rd(input int sel, input int k, input logic [XLEN-1:0] v, input string nm);
        chk_t e;
        e.sel = sel; e.port = k; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_all(input int sel, input logic [XLEN-1:0] v, input string nm);
        for (int k = 0; k < NRD; k++) exp_rd(sel, k, v, nm);
    endtask

    task automatic exp_busy(input logic v, input string nm);
        exp_rd(2, 0, {63'b0, v}, nm);
        exp_rd(3, 0, {63'b0, v}, nm);
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        raddr = {a3, a2, a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        wen   = en;
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    // Monitor: drains everything queued for the current cycle on the falling edge.
    initial begin
        chk_t            e;
        logic [XLEN-1:0] act;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       act = rdata_b[e.port*XLEN +: XLEN];
                    1:       act = rdata_n[e.port*XLEN +: XLEN];
                    2:       act = {63'b0, busy_b};
                    default: act = {63'b0, busy_n};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h",
                             e.name, e.sel, e.port, act, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_rd(5'd5, 5'd9, 5'd1, 5'd31);
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        step();
        checks++;
        if (busy_b !== 1'b1 || busy_n !== 1'b1) begin
            errors++;
            $display("FAIL direct_busy_after_reset: got %b/%b expected 1/1", busy_b, busy_n);
        end
        exp_busy(1'b1, "busy_after_reset");
        exp_all(0, 64'h0, "init_rd_zero");
        exp_all(1, 64'h0, "init_rd_zero");
        reset = 1'b0;

        // Writes late in the sweep target already-cleared registers and must be dropped.
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_busy(1'b1, "busy_during_init");
            if (i >= 25) set_wr(2'b11, 5'd9, 64'h1234, 5'd3, 64'h5678);
            if (i % 10 == 0) begin
                exp_all(0, 64'h0, "init_rd_zero");
                exp_all(1, 64'h0, "init_rd_zero");
            end
        end
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        checks++;
        if (busy_b !== 1'b0 || busy_n !== 1'b0) begin
            errors++;
            $display("FAIL direct_busy_low_32nd: got %b/%b expected 0/0", busy_b, busy_n);
        end
        exp_busy(1'b0, "busy_low_32nd");

        for (int g = 0; g < 8; g++) begin
            set_rd(5'(4*g), 5'(4*g+1), 5'(4*g+2), 5'(4*g+3));
            exp_all(0, 64'h0, "swept_zero");
            exp_all(1, 64'h0, "swept_zero");
            step();
        end

        set_wr(2'b01, 5'd5, 64'hDEAD_BEEF, 5'd0, 64'h0);
        set_rd(5'd5, 5'd5, 5'd5, 5'd5);
        exp_all(0, 64'hDEAD_BEEF, "x5_bypass");
        exp_all(1, 64'h0, "x5_no_bypass_old");
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        checks++;
        if (rdata_b[XLEN-1:0] !== 64'hDEAD_BEEF || rdata_n[XLEN-1:0] !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL direct_x5_stored: got %h/%h expected %h",
                     rdata_b[XLEN-1:0], rdata_n[XLEN-1:0], 64'hDEAD_BEEF);
        end
        exp_all(0, 64'hDEAD_BEEF, "x5_stored");
        exp_all(1, 64'hDEAD_BEEF, "x5_stored");
        step();

        set_wr(2'b11, 5'd7, 64'h1, 5'd7, 64'h2);
        set_rd(5'd7, 5'd7, 5'd7, 5'd7);
        exp_all(0, 64'h2, "x7_collide_bypass");
        exp_all(1, 64'h0, "x7_collide_no_bypass");
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        exp_all(0, 64'h2, "x7_port1_wins");
        exp_all(1, 64'h2, "x7_port1_wins");
        step();

        set_wr(2'b01, 5'd0, 64'hFFFF, 5'd0, 64'h0);
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        exp_all(0, 64'h0, "x0_write_cycle");
        exp_all(1, 64'h0, "x0_write_cycle");
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        exp_all(0, 64'h0, "x0_after");
        exp_all(1, 64'h0, "x0_after");
        step();

        set_wr(2'b01, 5'd3, 64'h55, 5'd0, 64'h0);
        set_rd(5'd3, 5'd5, 5'd7, 5'd0);
        exp_rd(0, 0, 64'h55, "x3_bypass");
        exp_rd(1, 0, 64'h0, "x3_no_bypass_old");
        for (int s = 0; s < 2; s++) begin
            exp_rd(s, 1, 64'hDEAD_BEEF, "mixed_x5");
            exp_rd(s, 2, 64'h2, "mixed_x7");
            exp_rd(s, 3, 64'h0, "mixed_x0");
        end
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        for (int s = 0; s < 2; s++) begin
            exp_rd(s, 0, 64'h55, "x3_stored");
            exp_rd(s, 1, 64'hDEAD_BEEF, "mixed_x5");
            exp_rd(s, 2, 64'h2, "mixed_x7");
            exp_rd(s, 3, 64'h0, "mixed_x0");
        end
        step();

        set_wr(2'b10, 5'd0, 64'h0, 5'd9, 64'hAA);
        set_rd(5'd9, 5'd9, 5'd9, 5'd9);
        exp_all(0, 64'hAA, "x9_bypass");
        exp_all(1, 64'h0, "x9_no_bypass_old");
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        exp_all(0, 64'hAA, "x9_stored");
        exp_all(1, 64'hAA, "x9_stored");
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_busy(1'b1, "busy_after_rerun_reset");
        exp_all(0, 64'h0, "reinit_rd_zero");
        exp_all(1, 64'h0, "reinit_rd_zero");
        set_wr(2'b11, 5'd9, 64'h77, 5'd9, 64'h88);
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_busy(1'b1, "busy_during_reinit");
        end
        step();
        set_wr(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
        exp_busy(1'b0, "busy_low_after_reinit");
        set_rd(5'd9, 5'd5, 5'd7, 5'd3);
        #1;
        checks++;
        if (rdata_b[XLEN-1:0] !== 64'h0 || rdata_n[XLEN-1:0] !== 64'h0) begin
            errors++;
            $display("FAIL direct_x9_reswept: got %h/%h expected 0",
                     rdata_b[XLEN-1:0], rdata_n[XLEN-1:0]);
        end
        exp_all(0, 64'h0, "reswept_zero");
        exp_all(1, 64'h0, "reswept_zero");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
